// File: rtl/mem_pkg.sv
// Shared encodings for the MAR/MDR memory responder: FSM states, request op
// and the wait-state counter sizing.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam int unsigned WAIT_MAX = 15;
  localparam int unsigned CNT_W    = $clog2(WAIT_MAX + 1);

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM: one read or one write per enabled edge.
// The read port only updates on an enabled read, so dout holds between reads.
module ram_sp #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array is deliberately not reset; contents survive reset and a
  // reset port would prevent mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches a MAR/MDR request, inserts WAIT_CYCLES wait
// states, performs one RAM access and holds mem_done under a 4-phase handshake.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_done,
  output logic              mem_busy,
  output logic              req_err
);

  localparam logic [CNT_W-1:0] WAIT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  op_e               op_q;
  logic              req_err_q, req_err_d;
  logic              rd_valid_q;
  logic              latch_en;
  logic              ram_en, ram_we;
  logic [DATA_W-1:0] ram_dout;
  logic              unused_addr_hi;

  // Upper MAR bits are outside the RAM and simply wrap.
  assign unused_addr_hi = ^addr[31:ADDR_W];

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_en  = 1'b0;
    req_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (read && write) begin
          req_err_d = 1'b1;
        end else if (read || write) begin
          latch_en = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_ACCESS;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE: begin
        if (!read && !write) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_q       <= OP_RD;
      req_err_q  <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_err_q <= req_err_d;
      if (latch_en) begin
        addr_q  <= addr[ADDR_W-1:0];
        wdata_q <= wdata;
        op_q    <= write ? OP_WR : OP_RD;
      end
      if (ram_en && !ram_we) rd_valid_q <= 1'b1;
    end
  end

  // The RAM is only touched on the ACCESS edge; reset pulls the state out of
  // WAIT asynchronously, so an interrupted write never reaches the array.
  assign ram_en = (state_q == ST_ACCESS);
  assign ram_we = ram_en && (op_q == OP_WR);

  ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .en   (ram_en),
    .addr (addr_q),
    .din  (wdata_q),
    .dout (ram_dout)
  );

  // The RAM read register has no reset, so rdata is masked to zero until the
  // first read after reset has loaded it.
  assign rdata    = rd_valid_q ? ram_dout : '0;
  assign mem_done = (state_q == ST_DONE);
  assign mem_busy = (state_q == ST_WAIT) || (state_q == ST_ACCESS);
  assign req_err  = req_err_q;

endmodule
